addsub_abs_pipe: RTL
====================

Name: addsub_abs_pipe

Overview:
Parametrised, pipelined two's-complement add/subtract unit with an optional absolute-value mode. It generalises the single-width combinational add-then-magnitude block in four ways:
- selectable operation;
- configurable width;
- status flags;
- a 2-stage registered pipeline with valid/ready handshake on both sides.

It sits between the operand-fetch/issue logic and writeback as a shared arithmetic resource that can be stalled by its consumer.

Parameters:
WIDTH, 32, operand and result width in bits (>= 4).

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands/op valid this cycle
in_ready  out  1  unit can accept operands this cycle
a  in  WIDTH  operand A (two's complement)
b  in  WIDTH  operand B (two's complement)
op  in  2  00 add (a+b); 01 sub (a-b); 10 abs(a+b); 11 abs(a-b)
out_valid  out  1  res/flags valid
out_ready  in  1  consumer accepts result this cycle
res  out  WIDTH  result
flag_c  out  1  carry-out of the WIDTH-bit add (sub: 1 = no borrow, a >= b unsigned)
flag_v  out  1  overflow (see Behaviour)
flag_n  out  1  negative (see Behaviour)
flag_z  out  1  res == 0

Behaviour:
Reset:
- rst high forces s1_valid = s2_valid = 0 and all stage registers to 0, asynchronously.
- Outputs go to: out_valid = 0, res = 0, all flags = 0, in_ready = 1.
- Any in-flight operation is discarded, with no output.

Stage 1 (registered):
- Computes the (WIDTH+1)-bit true result t = sext(a) +/- sext(b), using b' = ~b and carry-in 1 for subtraction.
- Captures the WIDTH-bit sum, carry-out, signed overflow (sign of a == sign of b' and sum sign differs), true sign t[WIDTH], and op[1].

Stage 2 (registered, drives outputs):
- add/sub (op[1] = 0):
  - res = sum[WIDTH-1:0]; flag_n = res[WIDTH-1]; flag_v = signed overflow; flag_c = carry-out.
- abs modes (op[1] = 1):
  - res = |t| as an unsigned WIDTH-bit value: if t[WIDTH] = 1, res = low WIDTH bits of (~t + 1); otherwise res = sum.
  - flag_n = t[WIDTH] (sign of the true result); flag_c = carry-out.
  - flag_v = 1 only when |t| = 2^WIDTH, which is the only unrepresentable magnitude. In that case res = 0.
  - The add/sub signed overflow does not set flag_v in abs modes, because the magnitude is exact.
- flag_z = (res == 0) in all modes.

Handshake:
- An input transfer occurs when in_valid && in_ready on a rising edge.
- An output transfer occurs when out_valid && out_ready.
- adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational, no dependence on in_valid).
- On adv2, stage 2 loads from stage 1 and s2_valid <= s1_valid.
- On adv1, stage 1 loads the inputs and s1_valid <= (in_valid && in_ready).
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle while out_ready = 1.

Stall:
- While out_valid && !out_ready, res and all flags hold stable.
- Stage 1 holds if it is full.
- in_ready drops only when both stages are full and out_ready = 0.
- Up to 2 results are buffered with no loss or duplication.

Other rules:
- Simultaneous accept-in and deliver-out on a full pipe is legal and keeps full throughput.
- a, b and op are don't-care when in_valid = 0. Stage data registers may update on bubbles, but stage valids must stay 0.
- Flags are valid only while out_valid = 1. They are 0 after reset.

Test Plan:
1. Reset, then op=00, a=0x7FFFFFFF, b=0x00000001 -> 2 cycles later: out_valid=1, res=0x80000000, v=1, n=1, c=0, z=0.
2. op=01, a=5, b=7 -> res=0xFFFFFFFE, n=1, c=0, v=0. Then op=11 with the same operands -> res=0x00000002, n=1, v=0.
3. op=10, a=0x80000000, b=0x80000000 -> res=0, v=1, n=1, c=1, z=1. Then op=01, a=3, b=3 -> res=0, z=1, c=1, n=0.
4. Back-to-back stream of 8 adds (a=i, b=10*i, i=0..7) with out_ready=1 -> results 0,11,...,77 on consecutive cycles starting 2 cycles after the first accept; in_ready stays 1.
5. Same stream with out_ready held 0 for 4 cycles mid-stream -> in_ready falls after 2 results are buffered; out held stable; after release, all 8 results arrive in order with no drop or duplicate.
6. Assert rst asynchronously (mid-cycle) with both stages full -> out_valid and res drop to 0 immediately without a clock edge; after release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/addsub_abs_pipe.sv
// Two-stage pipelined add/sub with optional absolute-value mode and NZCV-style flags.
// Stage 1 does the arithmetic and stage 2 forms the result; valid/ready handshake on both sides.
module addsub_abs_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_z
);

  logic             adv1, adv2;
  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_sum;
  logic             s1_c, s1_ovf, s1_sgn, s1_abs;

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   u_full;
  logic             sum_c, sum_ovf, t_sgn;

  logic [WIDTH-1:0] neg_sum;
  logic [WIDTH-1:0] res_nxt;
  logic             v_nxt, n_nxt;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid;

  always_comb begin
    bx      = op[0] ? ~b : b;
    u_full  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, op[0]};
    sum_c   = u_full[WIDTH];
    sum_ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (u_full[WIDTH-1] != a[WIDTH-1]);
    // Bit WIDTH of the sign-extended sum: both sign bits plus the carry out of the low WIDTH bits.
    t_sgn   = a[WIDTH-1] ^ bx[WIDTH-1] ^ u_full[WIDTH];
  end

  always_comb begin
    neg_sum = (~s1_sum) + {{(WIDTH-1){1'b0}}, 1'b1};
    res_nxt = s1_sum;
    v_nxt   = s1_ovf;
    n_nxt   = s1_sum[WIDTH-1];
    if (s1_abs) begin
      res_nxt = s1_sgn ? neg_sum : s1_sum;
      // Only t = -2^WIDTH has a magnitude that does not fit; it wraps to zero.
      v_nxt   = s1_sgn && (s1_sum == '0);
      n_nxt   = s1_sgn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_c     <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_sgn   <= 1'b0;
      s1_abs   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      s1_sum   <= u_full[WIDTH-1:0];
      s1_c     <= sum_c;
      s1_ovf   <= sum_ovf;
      s1_sgn   <= t_sgn;
      s1_abs   <= op[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res      <= '0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      res      <= res_nxt;
      flag_c   <= s1_c;
      flag_v   <= v_nxt;
      flag_n   <= n_nxt;
      flag_z   <= (res_nxt == '0);
    end
  end

endmodule
